// File: rtl/spi_sample_tx.sv
// SPI slave transmitter: captures a processed sample on the sequencer's
// main_read strobe and shifts it MSB-first to the MCU.
// The MCU is the SPI master in mode 0.
// sck and cs_n are synchronised into clk before any edge detection.
module spi_sample_tx #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              main_read,
  input  logic              tfr_ready,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sck,
  input  logic              cs_n,
  output logic              sdo,
  output logic              data_rdy,
  output logic              transmit,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOADED = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sck_hist_q;
  logic                   cs_hist_q;

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] shreg_q,    shreg_d;
  logic [CNT_W-1:0]  bitcnt_q,   bitcnt_d;
  logic              sdo_q,      sdo_d;
  logic              transmit_q, transmit_d;
  logic              overrun_q,  overrun_d;

  logic sck_s, cs_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  // Pin synchronisers plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_hist_q <= 1'b0;
      cs_hist_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sck_hist_q <= sck_sync_q[SYNC_STAGES-1];
      cs_hist_q  <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist_q;
  assign sck_fall = ~sck_s & sck_hist_q;
  assign cs_fall  = ~cs_s & cs_hist_q;
  assign cs_rise  = cs_s & ~cs_hist_q;

  // Next-state, shift register, bit counter, sdo and overrun
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    overrun_d = overrun_q;
    sdo_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (main_read) begin
          shreg_d  = sample_in;
          bitcnt_d = '0;
          state_d  = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (main_read) overrun_d = 1'b1;
        // An already-low cs_n does not start a frame; only a falling edge does
        if (cs_fall) begin
          state_d = ST_SHIFT;
          sdo_d   = shreg_q[DATA_W-1];
        end
      end
      ST_SHIFT: begin
        if (main_read) overrun_d = 1'b1;
        sdo_d = shreg_q[DATA_W-1];
        // A final rise coinciding with cs_rise completes the frame;
        // DONE then sees cs high and returns to IDLE.
        if (sck_rise) begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == LAST_BIT) state_d = ST_DONE;
        end else if (cs_rise) begin
          state_d  = ST_IDLE;
          shreg_d  = '0;
          bitcnt_d = '0;
          sdo_d    = 1'b0;
        end else if (sck_fall) begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        end
      end
      ST_DONE: begin
        if (main_read) begin
          shreg_d  = sample_in;
          bitcnt_d = '0;
          state_d  = ST_LOADED;
        end else if (cs_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    transmit_d = (state_d == ST_LOADED) || (state_d == ST_SHIFT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      sdo_q      <= 1'b0;
      transmit_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      sdo_q      <= sdo_d;
      transmit_q <= transmit_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sdo      = sdo_q;
  assign transmit = transmit_q;
  assign overrun  = overrun_q;
  assign data_rdy = tfr_ready && (state_q == ST_LOADED);

endmodule

// File: tb/tb_spi_sample_tx.sv
// Scoreboard bench: loads push expected frames, an SPI-side monitor
// captures sdo on each sck rise and compares whole frames on cs_n rise.
module tb_spi_sample_tx;

  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              main_read;
  logic              tfr_ready;
  logic [DATA_W-1:0] sample_in;
  logic              sck;
  logic              cs_n;
  logic              sdo;
  logic              data_rdy;
  logic              transmit;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got;
  int                mon_cnt = 0;

  spi_sample_tx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .main_read (main_read),
    .tfr_ready (tfr_ready),
    .sample_in (sample_in),
    .sck       (sck),
    .cs_n      (cs_n),
    .sdo       (sdo),
    .data_rdy  (data_rdy),
    .transmit  (transmit),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [DATA_W-1:0] v, input bit push);
    main_read = 1'b1;
    sample_in = v;
    tick(1);
    main_read = 1'b0;
    if (push) exp_q.push_back(v);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
      tick(8);
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    tick(8);
  endtask

  // Monitor: MCU side of the link
  always @(negedge cs_n) mon_cnt = 0;

  always @(posedge sck) begin
    if (cs_n == 1'b0) begin
      if (mon_cnt < int'(DATA_W)) got[DATA_W-1-mon_cnt] = sdo;
      else chk("extra_sck_sdo", 32'(sdo), 32'd0);
      mon_cnt++;
    end
  end

  always @(posedge cs_n) begin
    if (mon_cnt >= int'(DATA_W)) begin
      if (exp_q.size() == 0) begin
        chk("frame_unexpected", 32'(got), 32'hDEAD_BEEF);
      end else begin
        chk("frame_data", 32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; main_read = 1'b0; tfr_ready = 1'b0;
    sample_in = '0; sck = 1'b0; cs_n = 1'b1;
    tick(3);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_transmit", 32'(transmit), 32'd0);
    chk("rst_data_rdy", 32'(data_rdy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick(2);

    // Nominal frame
    do_read(16'hA5C3, 1'b1);
    chk("nom_transmit_t1", 32'(transmit), 32'd1);
    chk("nom_data_rdy_no_tfr", 32'(data_rdy), 32'd0);
    tick(1);
    chk("nom_transmit_t2", 32'(transmit), 32'd1);
    tfr_ready = 1'b1;
    #1;
    chk("nom_data_rdy", 32'(data_rdy), 32'd1);
    cs_low();
    pulses(8);
    chk("nom_transmit_mid", 32'(transmit), 32'd1);
    chk("nom_data_rdy_shift", 32'(data_rdy), 32'd0);
    pulses(8);
    chk("nom_transmit_end", 32'(transmit), 32'd0);
    chk("nom_sdo_end", 32'(sdo), 32'd0);
    cs_high();

    // Abort after 7 rises, then a 0x0001 frame
    do_read(16'hF0F0, 1'b0);
    cs_low();
    pulses(7);
    chk("abort_transmit_before", 32'(transmit), 32'd1);
    cs_n = 1'b1;
    tick(4);
    chk("abort_transmit", 32'(transmit), 32'd0);
    chk("abort_sdo", 32'(sdo), 32'd0);
    tick(4);
    do_read(16'h0001, 1'b1);
    cs_low();
    pulses(16);
    cs_high();

    // Overrun while LOADED
    chk("ovr_clear", 32'(overrun), 32'd0);
    do_read(16'h1234, 1'b1);
    tick(2);
    do_read(16'hFFFF, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_transmit", 32'(transmit), 32'd1);
    cs_low();
    pulses(16);
    cs_high();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // cs_n already low before the load
    cs_low();
    do_read(16'h5A3C, 1'b1);
    tick(2);
    pulses(4);
    chk("cslow_sdo", 32'(sdo), 32'd0);
    chk("cslow_transmit", 32'(transmit), 32'd1);
    chk("cslow_data_rdy", 32'(data_rdy), 32'd1);
    cs_high();
    cs_low();
    pulses(16);
    cs_high();

    // Overclocked sck: 20 pulses
    do_read(16'h8000, 1'b1);
    cs_low();
    pulses(16);
    chk("ovck_transmit", 32'(transmit), 32'd0);
    pulses(4);
    chk("ovck_sdo", 32'(sdo), 32'd0);
    cs_high();

    // Reset in the middle of a frame
    do_read(16'hC3C3, 1'b0);
    cs_low();
    pulses(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rstmid_transmit", 32'(transmit), 32'd0);
    chk("rstmid_sdo", 32'(sdo), 32'd0);
    chk("rstmid_data_rdy", 32'(data_rdy), 32'd0);
    chk("rstmid_overrun", 32'(overrun), 32'd0);
    cs_high();
    cs_low();
    pulses(4);
    chk("rstmid_idle_transmit", 32'(transmit), 32'd0);
    chk("rstmid_idle_sdo", 32'(sdo), 32'd0);
    cs_high();
    do_read(16'h6E21, 1'b1);
    cs_low();
    pulses(16);
    cs_high();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sample_tx.md
Name: spi_sample_tx

Overview:
- Downstream consumer of the datapath sequencer's main_read / tfr_ready strobes.
- On main_read, captures the processed audio sample and shifts it MSB-first to the MCU over SPI. The MCU is the bus master, mode 0.
- Drives the transmit handshake back to the sequencer. transmit stays high until the frame has been clocked out, then the sequencer returns to pause.
- All MCU pins are synchronised into the single FPGA clock domain.

Parameters:
- DATA_W, 16, sample width in bits (frame length in SCK cycles).
- SYNC_STAGES, 2, flip-flop stages on the sck and cs_n inputs (minimum 2).

Ports:
- clk  input  1  system clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- main_read  input  1  sequencer strobe: capture sample_in this cycle.
- tfr_ready  input  1  sequencer is in its MCU-transfer state.
- sample_in  input  DATA_W  processed sample (two's complement).
- sck  input  1  MCU SPI clock (asynchronous).
- cs_n  input  1  MCU chip select, active low (asynchronous).
- sdo  output  1  serial data to MCU (MISO).
- data_rdy  output  1  level to MCU interrupt pin: a sample is loaded and the sequencer is waiting.
- transmit  output  1  handshake to sequencer: a frame is pending or in progress.
- overrun  output  1  sticky: main_read arrived while a frame was pending or shifting.

Behaviour:
- Reset (synchronous, checked at posedge clk) forces the following. In-flight frames are discarded.
  - state=IDLE
  - shreg=0, bitcnt=0
  - sdo=0, transmit=0, data_rdy=0, overrun=0
  - synchroniser flops: sck→0, cs_n→1
- Synchronisers: sck and cs_n each pass through SYNC_STAGES flops plus one history flop.
  - sck_rise / sck_fall / cs_fall / cs_rise are single-cycle pulses from edge compare.
  - Pin-to-pulse latency is SYNC_STAGES+1 clk.
  - Requirement on the MCU: sck high and low phases of at least 4 clk each.
- States: IDLE, LOADED, SHIFT, DONE.
  - IDLE:
    - main_read=1: shreg<=sample_in, bitcnt<=0, go to LOADED.
    - sck/cs activity is ignored.
  - LOADED:
    - transmit=1.
    - data_rdy = tfr_ready (combinational AND with state).
    - cs_fall: go to SHIFT. An already-low cs_n does not start a frame; a falling edge is required.
  - SHIFT:
    - transmit=1, data_rdy=0.
    - sck_rise: bitcnt++. On the DATA_W-th rise, go to DONE.
    - sck_fall (bitcnt<DATA_W): shreg <= shreg<<1 (zero fill).
    - cs_rise before DATA_W rises: abort, go to IDLE. Data is discarded and transmit drops.
  - DONE:
    - transmit=0.
    - cs_rise: go to IDLE.
    - main_read: load the new sample and go to LOADED directly. A new cs_fall is still required before shifting.
- Handshake timing:
  - main_read in cycle t produces transmit=1 from cycle t+1.
  - The sequencer samples transmit two cycles after main_read and must see 1.
  - transmit falls in the cycle after the synchronised DATA_W-th sck_rise.
- sdo is registered:
  - sdo <= shreg[DATA_W-1] while state is SHIFT, or while LOADED with cs_fall; otherwise 0.
  - The MSB is valid before the first rising sck (mode 0). Each later bit changes the cycle after sck_fall.
  - After the frame, and in IDLE, sdo=0.
  - Extra sck pulses beyond DATA_W while cs_n is low are ignored; sdo stays 0.
- overrun:
  - Set when main_read=1 in LOADED or SHIFT. The captured data is unchanged and the state is unchanged.
  - Cleared only by reset.
- Simultaneous events:
  - main_read with reset: reset wins.
  - cs_rise on the same cycle as the DATA_W-th sck_rise: go to DONE, then IDLE the next cycle. Counted as complete, not aborted.
  - sck_rise and sck_fall cannot coincide, because of the minimum phase-width requirement.

Test Plan:
- Nominal frame (DATA_W=16):
  - Stimulus: main_read with sample_in=16'hA5C3, tfr_ready high 2 cycles later; MCU drops cs_n and clocks 16 sck at 8 clk per phase.
  - Required: transmit=1 from t+1; data_rdy=1 while LOADED; sdo bits captured on sck rise = 1010_0101_1100_0011; transmit=0 after the 16th rise; state IDLE after cs_n rises.
- Abort:
  - Stimulus: cs_n rises after 7 sck rises.
  - Required: transmit drops within SYNC_STAGES+2 clk; state IDLE; sdo=0.
  - Follow-up: the next main_read with 16'h0001 shifts out 15 zeros then a 1.
- Overrun:
  - Stimulus: load 16'h1234, then main_read with 16'hFFFF while LOADED.
  - Required: overrun=1 and sticky; shifted frame = 16'h1234.
- cs_n already low:
  - Stimulus: cs_n held low before main_read; sck toggles.
  - Required: no shifting and sdo=0 until cs_n goes high then low; then a full frame of the loaded value.
- Overclocked SCK:
  - Stimulus: 20 sck pulses with cs_n low after loading 16'h8000.
  - Required: first captured bit 1, then 15 zeros; sdo=0 on pulses 17–20; transmit=0 after the 16th.
- Reset mid-SHIFT:
  - Stimulus: reset after 5 bits.
  - Required: next cycle all outputs 0 and state IDLE; sck pulses afterward have no effect until a new main_read.
